// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the counter and the downstream
// Gray-to-binary decode stage.
package gray_pkg;

  localparam int GRAY_W     = 4;
  localparam int GRAY_MAX_W = 32;

  // What the counter does on a given edge.
  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_SAT  = 3'd4
  } cnt_op_e;

  // Operands narrower than GRAY_MAX_W are zero-extended.
  // Zero-extension does not change the result.
  function automatic logic [GRAY_MAX_W-1:0] bin2gray_f(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the prefix XOR of the Gray bits above it, including itself.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin_f(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary -> Gray encoder, WIDTH bits.
module gray_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray[WIDTH-1] = bin[WIDTH-1];

  genvar i;
  generate
    for (i = 0; i < WIDTH-1; i++) begin : g_bit
      assign gray[i] = bin[i] ^ bin[i+1];
    end
  endgenerate

endmodule

// File: rtl/gray_counter.sv
// Binary/Gray up/down counter with load, enable, and terminal count.
// WRAP selects roll-over or saturation at the ends.
// Define GRAY_CHK_EN to add a sticky Gray single-bit-change checker on err.
// Without GRAY_CHK_EN, err is tied to 0.
module gray_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_W,
  parameter int WRAP  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc,
  output logic             err
);

  logic [WIDTH-1:0] bin_q, gray_q, next_bin, gray_d;
  logic             at_top, at_bot, tc_w;
  cnt_op_e          op;

  // Classify the edge (load > en > hold) and form the next binary count.
  always_comb begin
    at_top   = (bin_q == {WIDTH{1'b1}});
    at_bot   = (bin_q == '0);
    tc_w     = en & ~load & ((up_dn & at_top) | (~up_dn & at_bot));
    op       = OP_HOLD;
    next_bin = bin_q;
    if (load) begin
      op       = OP_LOAD;
      next_bin = load_bin;
    end else if (en) begin
      if (tc_w && (WRAP == 0)) begin
        op       = OP_SAT;
      end else if (up_dn) begin
        op       = OP_INC;
        next_bin = bin_q + 1'b1;
      end else begin
        op       = OP_DEC;
        next_bin = bin_q - 1'b1;
      end
    end
  end

  gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (next_bin),
    .gray (gray_d)
  );

  // Binary and Gray registers share one edge, so the two outputs never skew.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      gray_q <= '0;
    end else begin
      bin_q  <= next_bin;
      gray_q <= gray_d;
    end
  end

  assign bin  = bin_q;
  assign gray = gray_q;
  assign tc   = tc_w;

`ifdef GRAY_CHK_EN
  logic [WIDTH-1:0] prev_q;
  logic             adv_q, err_q;

  // Check the transition made on the previous edge.
  // A counting step must flip exactly one Gray bit.
  // Load, hold, and saturate edges are exempt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= '0;
      adv_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= gray_q;
      adv_q  <= (op == OP_INC) || (op == OP_DEC);
      if (adv_q && ($countones(prev_q ^ gray_q) != 1)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_counter.sv
// Directed bench for gray_counter.
// Instance dut wraps at the ends; instance dut_sat saturates.
module tb_gray_counter;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, en, up_dn, load;
  logic [W-1:0] load_bin;
  logic [W-1:0] gray, bin, gray_s, bin_s;
  logic         tc, err, tc_s, err_s;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected Gray code for each binary value 0..15.
  logic [W-1:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                              4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .WRAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .gray(gray), .bin(bin), .tc(tc), .err(err)
  );

  gray_counter #(.WIDTH(W), .WRAP(0)) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
    .load_bin(load_bin), .gray(gray_s), .bin(bin_s), .tc(tc_s), .err(err_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] e;
    rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_bin = '0;
    #3;
    chk("rst_bin",  32'(bin),  32'h0);
    chk("rst_gray", 32'(gray), 32'h0);
    chk("rst_err",  32'(err),  32'h0);
    chk("rst_tc",   32'(tc),   32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Count up through a full lap.
    en = 1'b1; up_dn = 1'b1;
    #1;
    chk("up_tc0", 32'(tc), 32'h0);
    for (int i = 1; i <= 16; i++) begin
      step();
      e = W'(i % 16);
      chk($sformatf("up_bin%0d", i),  32'(bin),  32'(e));
      chk($sformatf("up_gray%0d", i), 32'(gray), 32'(gtab[e]));
      chk($sformatf("up_tc%0d", i),   32'(tc),   32'(e == 4'hF));
      // Saturating copy climbs to 1111 and stays there.
      chk($sformatf("sat_bin%0d", i),  32'(bin_s),  (i < 15) ? 32'(i) : 32'hF);
      chk($sformatf("sat_gray%0d", i), 32'(gray_s), (i < 15) ? 32'(gtab[i]) : 32'h8);
      chk($sformatf("sat_tc%0d", i),   32'(tc_s),   32'(i >= 15));
    end

    // Count down from 0, wrapping to 1111.
    up_dn = 1'b0;
    #1;
    chk("dn_tc_at0", 32'(tc), 32'h1);
    for (int i = 1; i <= 16; i++) begin
      step();
      e = W'((16 - i) % 16);
      chk($sformatf("dn_bin%0d", i),  32'(bin),  32'(e));
      chk($sformatf("dn_gray%0d", i), 32'(gray), 32'(gtab[e]));
      chk($sformatf("dn_tc%0d", i),   32'(tc),   32'(e == 4'h0));
    end

    // Load wins over enable and masks tc.
    load = 1'b1; load_bin = 4'h5;
    #1;
    chk("ld_tc_masked", 32'(tc), 32'h0);
    step();
    chk("ld_bin",  32'(bin),  32'h5);
    chk("ld_gray", 32'(gray), 32'h7);
    load = 1'b0; up_dn = 1'b1;
    step();
    chk("ld_up_bin",  32'(bin),  32'h6);
    chk("ld_up_gray", 32'(gray), 32'h5);
    up_dn = 1'b0;
    step();
    chk("dirchg_bin", 32'(bin), 32'h5);
    en = 1'b0;
    step();
    chk("hold_bin",  32'(bin),  32'h5);
    chk("hold_gray", 32'(gray), 32'h7);

    // Asynchronous reset mid-count at 1010.
    load = 1'b1; load_bin = 4'hA;
    step();
    chk("pre_rst_gray", 32'(gray), 32'hF);
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bin",   32'(bin),   32'h0);
    chk("arst_gray",  32'(gray),  32'h0);
    chk("arst_bin_s", 32'(bin_s), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_bin",  32'(bin),  32'h1);
    chk("post_rst_gray", 32'(gray), 32'h1);
    chk("err_idle", 32'(err), 32'h0);

`ifdef GRAY_CHK_EN
    // A legal load followed by counting must leave err clear.
    load = 1'b1; load_bin = 4'h5;
    step();
    load = 1'b0;
    step();
    step();
    chk("chk_legal_err", 32'(err), 32'h0);

    // Corrupt the Gray register after a counting edge; err must latch.
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    en = 1'b1; up_dn = 1'b1;
    step();
    step();
    chk("chk_pre_gray", 32'(gray), 32'h3);
    force dut.gray_q = 4'b0010;
    #1 release dut.gray_q;
    en = 1'b0;
    step();
    chk("chk_err_set", 32'(err), 32'h1);
    step();
    step();
    chk("chk_err_sticky", 32'(err), 32'h1);
    chk("chk_sat_err", 32'(err_s), 32'h0);
`else
    step();
    chk("err_tied0",   32'(err),   32'h0);
    chk("err_s_tied0", 32'(err_s), 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
